wmaj_trend_multi: RTL and testbench



---
 rtl/wmaj_trend_multi.sv | 145 ++++++++++++++
 tb/tb_wmaj_trend_multi.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/wmaj_trend_multi.sv
// Multi-channel weighted-majority trend detector with a two-stage pipeline
// and hysteresis thresholds. Each channel keeps a sliding window of DEPTH samples.
module wmaj_trend_multi #(
  parameter  int NCH    = 2,
  parameter  int DEPTH  = 8,
  parameter  int W_NEW  = 2,
  localparam int MAXSUM = (DEPTH / 2) * W_NEW + DEPTH / 2,
  localparam int SW     = $clog2(MAXSUM + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [NCH-1:0]    sample_in,
  input  logic [SW-1:0]     th_hi,
  input  logic [SW-1:0]     th_lo,
  output logic [NCH-1:0]    trend,
  output logic [NCH*SW-1:0] sum_out,
  output logic              out_valid,
  output logic              primed
);

  localparam int          CW   = $clog2(DEPTH + 1);
  localparam int unsigned HALF = DEPTH / 2;

  logic [NCH-1:0][DEPTH-1:0] win_q, win_d;
  logic [NCH-1:0][SW-1:0]    sum_calc;
  logic [NCH-1:0][SW-1:0]    sum_q, sum_d;
  logic [NCH-1:0][SW-1:0]    sum_out_q, sum_out_d;
  logic [NCH-1:0]            trend_q, trend_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [CW-1:0]             cnt1_q, cnt1_d;
  logic [CW-1:0]             cnt2_q, cnt2_d;
  logic                      v1_q, v1_d;
  logic                      v2_q, v2_d;
  logic                      out_valid_q, out_valid_d;
  logic                      primed_q, primed_d;

  // Newest half of the window (bits 0..HALF-1) carries weight W_NEW.
  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      sum_calc[c] = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (win_q[c][i]) begin
          sum_calc[c] = sum_calc[c] + ((i < HALF) ? SW'(W_NEW) : SW'(1));
        end
      end
    end
  end

  always_comb begin
    win_d       = win_q;
    cnt_d       = cnt_q;
    v1_d        = 1'b0;
    cnt1_d      = cnt1_q;
    sum_d       = sum_q;
    v2_d        = 1'b0;
    cnt2_d      = cnt2_q;
    sum_out_d   = sum_out_q;
    trend_d     = trend_q;
    out_valid_d = 1'b0;
    primed_d    = primed_q;

    if (sample_valid) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        win_d[c] = {win_q[c][DEPTH-2:0], sample_in[c]};
      end
      if (cnt_q != CW'(DEPTH)) begin
        cnt_d = cnt_q + 1'b1;
      end
      v1_d   = 1'b1;
      cnt1_d = cnt_d;
    end

    if (v1_q) begin
      sum_d  = sum_calc;
      v2_d   = 1'b1;
      cnt2_d = cnt1_q;
    end

    // The DEPTH-th result already sees itself as primed, so its trend applies.
    if (v2_q) begin
      out_valid_d = 1'b1;
      sum_out_d   = sum_q;
      if (primed_q || (cnt2_q == CW'(DEPTH))) begin
        primed_d = 1'b1;
        for (int unsigned c = 0; c < NCH; c++) begin
          if (sum_q[c] >= th_hi) begin
            trend_d[c] = 1'b1;
          end else if (sum_q[c] <= th_lo) begin
            trend_d[c] = 1'b0;
          end
        end
      end
    end

    if (clear) begin
      win_d       = '0;
      cnt_d       = '0;
      v1_d        = 1'b0;
      cnt1_d      = '0;
      sum_d       = '0;
      v2_d        = 1'b0;
      cnt2_d      = '0;
      sum_out_d   = '0;
      trend_d     = '0;
      out_valid_d = 1'b0;
      primed_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q       <= '0;
      cnt_q       <= '0;
      v1_q        <= 1'b0;
      cnt1_q      <= '0;
      sum_q       <= '0;
      v2_q        <= 1'b0;
      cnt2_q      <= '0;
      sum_out_q   <= '0;
      trend_q     <= '0;
      out_valid_q <= 1'b0;
      primed_q    <= 1'b0;
    end else begin
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      v1_q        <= v1_d;
      cnt1_q      <= cnt1_d;
      sum_q       <= sum_d;
      v2_q        <= v2_d;
      cnt2_q      <= cnt2_d;
      sum_out_q   <= sum_out_d;
      trend_q     <= trend_d;
      out_valid_q <= out_valid_d;
      primed_q    <= primed_d;
    end
  end

  assign trend     = trend_q;
  assign sum_out   = sum_out_q;
  assign out_valid = out_valid_q;
  assign primed    = primed_q;

endmodule

// File: tb/tb_wmaj_trend_multi.sv
// Directed, table-driven bench for wmaj_trend_multi (NCH=2, DEPTH=8, W_NEW=2).
// Each table row drives one clock edge and lists the outputs expected just after it.
module tb_wmaj_trend_multi;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       sample_valid;
  logic [1:0] sample_in;
  logic [3:0] th_hi;
  logic [3:0] th_lo;
  logic [1:0] trend;
  logic [7:0] sum_out;
  logic       out_valid;
  logic       primed;

  int vectors;
  int miscompares;

  typedef struct {
    logic       clr;
    logic       sv;
    logic [1:0] si;
    logic       ov;
    logic       pr;
    logic [1:0] tr;
    logic [3:0] s0;
    logic [3:0] s1;
  } vec_t;

  vec_t tbl[38];

  wmaj_trend_multi #(.NCH(2), .DEPTH(8), .W_NEW(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .th_hi        (th_hi),
    .th_lo        (th_lo),
    .trend        (trend),
    .sum_out      (sum_out),
    .out_valid    (out_valid),
    .primed       (primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic clr, input logic sv, input logic [1:0] si,
                              input logic ov, input logic pr, input logic [1:0] tr,
                              input logic [3:0] s0, input logic [3:0] s1);
    vec_t v;
    v.clr = clr; v.sv = sv; v.si = si; v.ov = ov;
    v.pr  = pr;  v.tr = tr; v.s0 = s0; v.s1 = s1;
    return v;
  endfunction

  task automatic check(input string name, input logic ov, input logic pr,
                       input logic [1:0] tr, input logic [3:0] s0, input logic [3:0] s1);
    vectors++;
    if (out_valid !== ov || primed !== pr || trend !== tr ||
        sum_out[3:0] !== s0 || sum_out[7:4] !== s1) begin
      miscompares++;
      $display("FAIL %s: got ov=%b pr=%b tr=%b s0=%0d s1=%0d, want ov=%b pr=%b tr=%b s0=%0d s1=%0d",
               name, out_valid, primed, trend, sum_out[3:0], sum_out[7:4],
               ov, pr, tr, s0, s1);
    end
  endtask

  task automatic step(input logic clr, input logic sv, input logic [1:0] si);
    clear        = clr;
    sample_valid = sv;
    sample_in    = si;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    clear        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = 2'b00;
    th_hi        = 4'd7;
    th_lo        = 4'd4;

    // Trend profile on ch0: 0000 1111 then 1 then 0000.
    tbl[0]  = mk(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
    tbl[1]  = mk(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
    tbl[2]  = mk(1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0);
    tbl[3]  = mk(1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0);
    tbl[4]  = mk(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0);
    tbl[5]  = mk(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0);
    tbl[6]  = mk(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 4'd2, 4'd0);
    tbl[7]  = mk(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 4'd4, 4'd0);
    tbl[8]  = mk(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 4'd6, 4'd0);
    tbl[9]  = mk(1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 2'd1, 4'd8, 4'd0);
    tbl[10] = mk(1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 2'd1, 4'd9, 4'd0);
    tbl[11] = mk(1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 2'd1, 4'd8, 4'd0);
    tbl[12] = mk(1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 2'd1, 4'd7, 4'd0);
    tbl[13] = mk(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 4'd6, 4'd0);
    tbl[14] = mk(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 4'd4, 4'd0);
    tbl[15] = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 4'd4, 4'd0);
    // Sample in flight, then clear with a simultaneous (dropped) sample.
    tbl[16] = mk(1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 2'd0, 4'd4, 4'd0);
    tbl[17] = mk(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
    tbl[18] = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
    tbl[19] = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
    // Eight ones on ch1, zeros on ch0: saturation, pre-prime gating, re-prime.
    tbl[20] = mk(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
    tbl[21] = mk(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
    tbl[22] = mk(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 4'd0, 4'd2);
    tbl[23] = mk(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 4'd0, 4'd4);
    tbl[24] = mk(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 4'd0, 4'd6);
    tbl[25] = mk(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 4'd0, 4'd8);
    tbl[26] = mk(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 4'd0, 4'd9);
    tbl[27] = mk(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 4'd0, 4'd10);
    tbl[28] = mk(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0, 4'd11);
    tbl[29] = mk(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 4'd0, 4'd12);
    tbl[30] = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 4'd0, 4'd12);
    // Gapped strobes: windows hold across idle cycles.
    tbl[31] = mk(1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 2'd2, 4'd0, 4'd12);
    tbl[32] = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 4'd0, 4'd12);
    tbl[33] = mk(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 4'd2, 4'd10);
    tbl[34] = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 4'd2, 4'd10);
    tbl[35] = mk(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd2, 4'd2, 4'd10);
    tbl[36] = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 4'd2, 4'd10);
    tbl[37] = mk(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 4'd2, 4'd8);

    // Reset held, then released with no samples.
    #1;
    check("reset_async", 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'd0);
      check("reset_hold", 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'd0);
      check("idle_after_reset", 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
    end

    for (int i = 0; i < 38; i++) begin
      step(tbl[i].clr, tbl[i].sv, tbl[i].si);
      check($sformatf("vec%0d", i), tbl[i].ov, tbl[i].pr, tbl[i].tr, tbl[i].s0, tbl[i].s1);
    end

    // Async reset while a sample sits in stage 1.
    step(1'b0, 1'b1, 2'd3);
    check("pre_reset_inflight", 1'b0, 1'b1, 2'd2, 4'd2, 4'd8);
    sample_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_midpipe", 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 2'd0);
      check("no_stray_valid", 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
